reg_file_issue: RTL and testbench
=================================

# reg_file_issue

Register-file and issue stage sitting directly upstream of the combinational decode/execute unit. It accepts 9-bit instructions over a valid/ready handshake and reads two 4-bit operands from a 4-entry register file. It presents opcode and operands to the execute unit for one cycle, then writes the returned 4-bit result back into the register file, sustaining one instruction per cycle.

## Interface
Parameters:
- NUM_REGS, 4: register count; the address width is log2(NUM_REGS) = 2 and is fixed by the instruction format.
- RESET_VAL, 4'h0: reset value of every register.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block accepts this cycle.
- instr  in  9  [8:6] op, [5:4] dst, [3:2] src_s, [1:0] src_t.
- ex_valid  out  1  ex_* outputs carry a live instruction.
- ex_op_code  out  3  opcode to execute unit.
- ex_rs  out  4  operand from reg[src_s].
- ex_rt  out  4  operand from reg[src_t].
- ex_rd  in  4  combinational result from execute unit, same cycle.
- wb_valid  out  1  one-cycle pulse after a register write.
- wb_addr  out  2  register written.
- wb_data  out  4  value written.
- dbg_addr  in  2  debug read address.
- dbg_data  out  4  combinational read of reg[dbg_addr].

## Operation
- Accept on instr_valid && instr_ready at a rising edge (E0).
- At E0, the issue register (IS) captures op, dst and both operand values, then sets is_valid.
- While is_valid = 1: ex_valid = 1 and ex_* driven from IS. While is_valid = 0: ex_op_code, ex_rs and ex_rt are driven to 0.
- At the next edge (E1), if is_valid: reg[dst] <= ex_rd. wb_valid, wb_addr and wb_data register the write. is_valid reloads from the handshake, or clears if there was no accept.
- All 8 opcodes write back, including 111 (multiply). Only ex_rd[3:0] is stored, so results wrap modulo 16.
- Hazard: an instruction accepted at E1 whose src_s or src_t equals the in-flight IS dst would otherwise read a stale value.
- Writes to one register on consecutive cycles: the later write wins.
- dbg_data reads the array directly. During the cycle before E1 it shows the old value; it shows the new value after E1.

## Timing
- Reset (async, immediate): all registers = RESET_VAL; is_valid = 0; ex_valid = 0; ex_* = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; instr_ready = 0 while rst_n is low.
- Latency: ex_* valid in the cycle after E0. The register updates at E1. wb_valid is high in the cycle after E1. Result visible on dbg_data 2 edges after accept.
- Throughput: 1 instruction/cycle when no stall is required.
- Reset mid-flight: the in-flight instruction is discarded, no write occurs, and wb_valid does not pulse.
- instr_ready is combinational from is_valid, the IS dst and the instr fields. instr_valid must not depend on instr_ready.

## Configuration
- REG_FILE_FORWARD_EN defined:
  - The operand read muxes ex_rd in place of the array value when is_valid && (src == IS dst).
  - instr_ready = 1 whenever rst_n is high.
- REG_FILE_FORWARD_EN undefined:
  - instr_ready = 0 when is_valid && (instr_valid) && (src_s == IS dst || src_t == IS dst).
  - This inserts exactly one bubble; the stalled instruction is accepted the following cycle with the written value.

## Structure
- Shared package: opcode constants (OP_ADD 000, OP_ADD_NOT 001, OP_INC 010, OP_NOR 011, OP_NAND 100, OP_SHR2 101, OP_SHL1 110, OP_MUL 111), instruction field bit positions, data width 4, address width 2.
- One sub-module, reg_file_4x4:
  - Two combinational read ports plus a debug read port.
  - One synchronous write port.
  - Asynchronous active-low reset to RESET_VAL.
- Issue register, forwarding/stall logic and writeback registers live in the top module.

## Test plan
- Reset: hold rst_n low 3 cycles -> ex_valid = 0, wb_valid = 0, dbg_data = 0 for all addresses, instr_ready = 0; release -> instr_ready = 1.
- Single INC: op 010, dst 1, src_s 1 with the execute model returning rs+1 -> ex_rs = 0 for one cycle; wb_valid pulse with wb_addr = 1, wb_data = 1; dbg_data(1) = 1.
- Dependent burst: three back-to-back INC r1 -> r1 = 3.
  - With REG_FILE_FORWARD_EN: instr_ready stays 1, and ex_rs is 0, 1, 2 on consecutive cycles.
  - Without it: instr_ready drops for one cycle before the 2nd and 3rd instructions, giving 5 cycles total.
- Arithmetic wrap: r1 = 3; ADD r2 = r1 + r1 -> wb_data = 6; MUL r3 = r2 * r2 -> wb_data = 4 (36 mod 16).
- Reset mid-flight: accept INC r0, pull rst_n low before E1 -> r0 = 0, no wb_valid pulse, ex_valid = 0 immediately.
- Idle gaps: instr_valid low for 2 cycles between instructions -> ex_valid low and ex_* = 0 in the gap cycles, and no writes occur.

Source files
------------

// File: rtl/reg_file_issue_pkg.sv
// Shared types and constants for the reg_file_issue slice: opcodes, instruction
// field positions and the data/address widths of the 4x4 register file.
package reg_file_issue_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 9;

  localparam int OP_MSB    = 8;
  localparam int OP_LSB    = 6;
  localparam int DST_MSB   = 5;
  localparam int DST_LSB   = 4;
  localparam int SRC_S_MSB = 3;
  localparam int SRC_S_LSB = 2;
  localparam int SRC_T_MSB = 1;
  localparam int SRC_T_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_ADD_NOT = 3'b001,
    OP_INC     = 3'b010,
    OP_NOR     = 3'b011,
    OP_NAND    = 3'b100,
    OP_SHR2    = 3'b101,
    OP_SHL1    = 3'b110,
    OP_MUL     = 3'b111
  } opcode_e;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    opcode_e op;
    addr_t   dst;
    addr_t   src_s;
    addr_t   src_t;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] raw);
    instr_t f;
    f.op    = opcode_e'(raw[OP_MSB:OP_LSB]);
    f.dst   = raw[DST_MSB:DST_LSB];
    f.src_s = raw[SRC_S_MSB:SRC_S_LSB];
    f.src_t = raw[SRC_T_MSB:SRC_T_LSB];
    return f;
  endfunction

endpackage

// File: rtl/reg_file_4x4.sv
// Four 4-bit registers: two combinational operand read ports, a debug read
// port and one synchronous write port; async active-low reset to RESET_VAL.
module reg_file_4x4
  import reg_file_issue_pkg::*;
#(
  parameter int    NUM_REGS  = 4,
  parameter data_t RESET_VAL = 4'h0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr_s,
  output data_t rdata_s,
  input  addr_t raddr_t,
  output data_t rdata_t,
  input  addr_t dbg_addr,
  output data_t dbg_data
);

  data_t regs [NUM_REGS];

  // NOTE: this array is only four flops, so it is reset like ordinary state;
  // a real RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_s  = regs[raddr_s];
  assign rdata_t  = regs[raddr_t];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/reg_file_issue.sv
// Register-file read / issue stage feeding a combinational execute unit and
// writing its result back. Define REG_FILE_FORWARD_EN to bypass ex_rd into the
// operand reads instead of stalling on a read-after-write hazard.
module reg_file_issue
  import reg_file_issue_pkg::*;
#(
  parameter int    NUM_REGS  = 4,
  parameter data_t RESET_VAL = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               ex_valid,
  output logic [2:0]         ex_op_code,
  output logic [DATA_W-1:0]  ex_rs,
  output logic [DATA_W-1:0]  ex_rt,
  input  logic [DATA_W-1:0]  ex_rd,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  instr_t  in_f;
  data_t   arr_s, arr_t;
  data_t   rd_s, rd_t;
  logic    accept;

  logic    is_valid;
  opcode_e is_op;
  addr_t   is_dst;
  data_t   is_rs, is_rt;

  assign in_f = unpack_instr(instr);

  reg_file_4x4 #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (is_valid),
    .waddr    (is_dst),
    .wdata    (ex_rd),
    .raddr_s  (in_f.src_s),
    .rdata_s  (arr_s),
    .raddr_t  (in_f.src_t),
    .rdata_t  (arr_t),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef REG_FILE_FORWARD_EN
  // The in-flight result is this cycle's ex_rd, so bypass it over the stale array value.
  assign rd_s        = (is_valid && (in_f.src_s == is_dst)) ? ex_rd : arr_s;
  assign rd_t        = (is_valid && (in_f.src_t == is_dst)) ? ex_rd : arr_t;
  assign instr_ready = rst_n;
`else
  logic hazard;
  assign hazard      = is_valid && instr_valid &&
                       ((in_f.src_s == is_dst) || (in_f.src_t == is_dst));
  assign rd_s        = arr_s;
  assign rd_t        = arr_t;
  assign instr_ready = rst_n && !hazard;
`endif

  assign accept = instr_valid && instr_ready;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_valid <= 1'b0;
      is_op    <= OP_ADD;
      is_dst   <= '0;
      is_rs    <= '0;
      is_rt    <= '0;
    end else begin
      is_valid <= accept;
      if (accept) begin
        is_op  <= in_f.op;
        is_dst <= in_f.dst;
        is_rs  <= rd_s;
        is_rt  <= rd_t;
      end
    end
  end

  // Writeback mirror: address/data hold the last write between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= is_valid;
      if (is_valid) begin
        wb_addr <= is_dst;
        wb_data <= ex_rd;
      end
    end
  end

  // NOTE: every output gets a default before the conditional so no latch is inferred.
  always_comb begin
    ex_valid   = is_valid;
    ex_op_code = '0;
    ex_rs      = '0;
    ex_rt      = '0;
    if (is_valid) begin
      ex_op_code = is_op;
      ex_rs      = is_rs;
      ex_rt      = is_rt;
    end
  end

endmodule

// File: tb/tb_reg_file_issue.sv
// Directed self-checking bench for reg_file_issue with a behavioural execute
// unit model; expectations follow REG_FILE_FORWARD_EN when it is defined.
`timescale 1ns/100ps
module tb_reg_file_issue;
  import reg_file_issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [8:0] instr = '0;
  logic       ex_valid;
  logic [2:0] ex_op_code;
  logic [3:0] ex_rs, ex_rt, ex_rd;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [3:0] wb_data;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;
  logic [7:0] prod;

  int n_vec = 0;
  int n_err = 0;

`ifdef REG_FILE_FORWARD_EN
  localparam int         BURST_N   = 3;
  localparam logic [4:0] BURST_RDY = 5'b00111;
  localparam logic [4:0] BURST_EXV = 5'b00110;
  localparam logic [3:0] BURST_RS [5] = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
`else
  localparam int         BURST_N   = 5;
  localparam logic [4:0] BURST_RDY = 5'b10101;
  localparam logic [4:0] BURST_EXV = 5'b01010;
  localparam logic [3:0] BURST_RS [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
`endif

  reg_file_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ex_valid    (ex_valid),
    .ex_op_code  (ex_op_code),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural execute unit: results truncated to 4 bits.
  always_comb begin
    prod = ex_rs * ex_rt;
    case (ex_op_code)
      3'b000:  ex_rd = ex_rs + ex_rt;
      3'b001:  ex_rd = ex_rs + ~ex_rt;
      3'b010:  ex_rd = ex_rs + 4'd1;
      3'b011:  ex_rd = ~(ex_rs | ex_rt);
      3'b100:  ex_rd = ~(ex_rs & ex_rt);
      3'b101:  ex_rd = ex_rs >> 2;
      3'b110:  ex_rd = ex_rs << 1;
      default: ex_rd = prod[3:0];
    endcase
  end

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] d,
                                    input logic [1:0] s, input logic [1:0] t);
    return {op, d, s, t};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input logic [1:0] a, input logic [3:0] e, input string tag);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, e);
  endtask

  // Present one instruction, wait (bounded) for acceptance, then check ex and writeback.
  task automatic run_one(input logic [8:0] ins, input logic [1:0] wa,
                         input logic [3:0] wd, input string tag);
    logic [2:0] op;
    int waited;
    op = ins[8:6];
    waited = 0;
    instr = ins;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_accepted"}, instr_ready, 1'b1);
    tick();
    instr_valid = 1'b0;
    #1;
    check({tag, "_ex_valid"}, ex_valid, 1'b1);
    check({tag, "_ex_op"}, ex_op_code, op);
    tick();
    check({tag, "_wb_valid"}, wb_valid, 1'b1);
    check({tag, "_wb_addr"}, wb_addr, wa);
    check({tag, "_wb_data"}, wb_data, wd);
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_ready", instr_ready, 1'b0);
    check("rst_ex_op", ex_op_code, 3'd0);
    check("rst_ex_rs", ex_rs, 4'd0);
    for (int a = 0; a < 4; a++) dbg_check(a[1:0], 4'd0, "rst_dbg");
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", instr_ready, 1'b1);

    // Single INC r1 = r1 + 1
    tick();
    instr = mk(3'b010, 2'd1, 2'd1, 2'd0);
    instr_valid = 1'b1;
    #1;
    check("inc_ready", instr_ready, 1'b1);
    tick();
    instr_valid = 1'b0;
    #1;
    check("inc_ex_valid", ex_valid, 1'b1);
    check("inc_ex_op", ex_op_code, 3'b010);
    check("inc_ex_rs", ex_rs, 4'd0);
    dbg_check(2'd1, 4'd0, "inc_dbg_old");
    tick();
    check("inc_wb_valid", wb_valid, 1'b1);
    check("inc_wb_addr", wb_addr, 2'd1);
    check("inc_wb_data", wb_data, 4'd1);
    check("inc_ex_valid_drop", ex_valid, 1'b0);
    dbg_check(2'd1, 4'd1, "inc_dbg_new");
    tick();
    check("inc_wb_pulse_end", wb_valid, 1'b0);

    // Dependent burst of three INC r1 from a clean register file
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < BURST_N; c++) begin
      instr = mk(3'b010, 2'd1, 2'd1, 2'd0);
      instr_valid = 1'b1;
      #1;
      check("burst_ready", instr_ready, BURST_RDY[c]);
      check("burst_ex_valid", ex_valid, BURST_EXV[c]);
      check("burst_ex_rs", ex_rs, BURST_RS[c]);
      tick();
    end
    instr_valid = 1'b0;
    #1;
    check("burst_last_ex_valid", ex_valid, 1'b1);
    check("burst_last_ex_rs", ex_rs, 4'd2);
    tick();
    check("burst_wb_valid", wb_valid, 1'b1);
    check("burst_wb_data", wb_data, 4'd3);
    dbg_check(2'd1, 4'd3, "burst_dbg_r1");

    // Arithmetic wrap: r2 = r1 + r1 = 6, r3 = r2 * r2 = 36 mod 16 = 4
    run_one(mk(3'b000, 2'd2, 2'd1, 2'd1), 2'd2, 4'd6, "add");
    run_one(mk(3'b111, 2'd3, 2'd2, 2'd2), 2'd3, 4'd4, "mul");
    dbg_check(2'd3, 4'd4, "mul_dbg_r3");

    // Reset while an INC r0 sits in the issue register
    tick();
    instr = mk(3'b010, 2'd0, 2'd0, 2'd0);
    instr_valid = 1'b1;
    #1;
    tick();
    instr_valid = 1'b0;
    #1;
    check("midrst_ex_valid_before", ex_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_ex_valid", ex_valid, 1'b0);
    check("midrst_ex_op", ex_op_code, 3'd0);
    check("midrst_wb_valid", wb_valid, 1'b0);
    check("midrst_ready", instr_ready, 1'b0);
    tick();
    check("midrst_wb_valid_edge", wb_valid, 1'b0);
    dbg_check(2'd0, 4'd0, "midrst_dbg_r0");
    dbg_check(2'd1, 4'd0, "midrst_dbg_r1");
    rst_n = 1'b1;
    tick();
    check("midrst_wb_valid_after", wb_valid, 1'b0);
    dbg_check(2'd0, 4'd0, "midrst_dbg_r0_after");

    // Idle gaps: issue register content must be masked while not valid
    run_one(mk(3'b010, 2'd0, 2'd0, 2'd0), 2'd0, 4'd1, "gap_inc1");
    run_one(mk(3'b010, 2'd0, 2'd0, 2'd0), 2'd0, 4'd2, "gap_inc2");
    instr = mk(3'b010, 2'd0, 2'd0, 2'd0);
    instr_valid = 1'b1;
    #1;
    check("gap_inc3_ready", instr_ready, 1'b1);
    tick();
    instr_valid = 1'b0;
    #1;
    check("gap_inc3_ex_rs", ex_rs, 4'd2);
    check("gap_inc3_ex_rt", ex_rt, 4'd2);
    tick();
    check("gap_inc3_wb_data", wb_data, 4'd3);
    for (int g = 0; g < 2; g++) begin
      tick();
      check("gap_ex_valid", ex_valid, 1'b0);
      check("gap_ex_op", ex_op_code, 3'd0);
      check("gap_ex_rs", ex_rs, 4'd0);
      check("gap_ex_rt", ex_rt, 4'd0);
      check("gap_wb_valid", wb_valid, 1'b0);
      dbg_check(2'd0, 4'd3, "gap_dbg_r0");
    end
    run_one(mk(3'b000, 2'd1, 2'd0, 2'd0), 2'd1, 4'd6, "gap_add");
    dbg_check(2'd1, 4'd6, "gap_dbg_r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
